mcb_cmd_arbiter: RTL and testbench

MCB_CMD_ARBITER -- requirements
Module: mcb_cmd_arbiter

---
 rtl/mcb_cmd_arbiter.sv | 149 ++++++++++++++
 tb/tb_mcb_cmd_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_cmd_arbiter.sv
// mcb_cmd_arbiter: arbitrates a writer and a reader onto one MCB command port.
// A command issues at most every 3 cycles (IDLE -> ISSUE -> GAP). The reader
// can be boosted by urgency, and a starvation counter guarantees the writer
// eventually wins.
module mcb_cmd_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_calib_done,
   input  logic             cmd_full,
   input  logic [6:0]       wr_count,
   input  logic             w_req,
   input  logic [2:0]       w_instr,
   input  logic [5:0]       w_bl,
   input  logic [29:0]      w_addr,
   input  logic             r_req,
   input  logic [2:0]       r_instr,
   input  logic [5:0]       r_bl,
   input  logic [29:0]      r_addr,
   input  logic             r_urgent,
   output logic             w_gnt,
   output logic             r_gnt,
   output logic             cmd_en,
   output logic [2:0]       cmd_instr,
   output logic [5:0]       cmd_bl,
   output logic [29:0]      cmd_byte_addr,
   output logic             align_err,
   output logic [CNT_W-1:0] w_issued,
   output logic [CNT_W-1:0] r_issued
);

   typedef enum logic [1:0] {
      CALIB,
      IDLE,
      ISSUE,
      GAP
   } state_t;

   localparam logic [3:0] STARVE_THRESH = 4'(STARVE_LIMIT);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  starve_cnt;
   logic        last_gnt_w;
   logic        w_elig;
   logic        r_elig;
   logic        pick_w;
   logic        pick_r;
   logic        issue_now;
   logic [2:0]  win_instr;
   logic [5:0]  win_bl;
   logic [29:0] win_addr;
   logic        win_misaligned;

   // Eligibility and winner selection; the writer needs a full burst of data already in the write FIFO
   always_comb begin
      w_elig         = w_req && !cmd_full && (wr_count >= ({1'b0, w_bl} + 7'd1));
      r_elig         = r_req && !cmd_full;
      pick_w         = 1'b0;
      pick_r         = 1'b0;
      if (w_elig && (starve_cnt >= STARVE_THRESH)) begin
         pick_w = 1'b1;
      end else if (r_elig && r_urgent) begin
         pick_r = 1'b1;
      end else if (w_elig && r_elig) begin
         pick_w = !last_gnt_w;
         pick_r = last_gnt_w;
      end else if (w_elig) begin
         pick_w = 1'b1;
      end else if (r_elig) begin
         pick_r = 1'b1;
      end
      issue_now      = (state == IDLE) && mem_calib_done && (pick_w || pick_r);
      win_instr      = pick_w ? w_instr : r_instr;
      win_bl         = pick_w ? w_bl    : r_bl;
      win_addr       = pick_w ? w_addr  : r_addr;
      win_misaligned = (win_addr[1:0] != 2'b00);
   end

   // Next-state logic; losing calibration always forces a return to CALIB
   always_comb begin
      state_nxt = state;
      if (!mem_calib_done) begin
         state_nxt = CALIB;
      end else begin
         case (state)
            CALIB:   state_nxt = IDLE;
            IDLE:    state_nxt = issue_now ? ISSUE : IDLE;
            ISSUE:   state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = CALIB;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CALIB;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered command outputs, grants, counters and fairness bookkeeping, all loaded on the IDLE->ISSUE edge
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_en        <= 1'b0;
         w_gnt         <= 1'b0;
         r_gnt         <= 1'b0;
         align_err     <= 1'b0;
         cmd_instr     <= 3'd0;
         cmd_bl        <= 6'd0;
         cmd_byte_addr <= 30'd0;
         w_issued      <= '0;
         r_issued      <= '0;
         starve_cnt    <= 4'd0;
         last_gnt_w    <= 1'b0;
      end else begin
         cmd_en <= 1'b0;
         w_gnt  <= 1'b0;
         r_gnt  <= 1'b0;
         if (issue_now) begin
            cmd_en        <= !win_misaligned;
            w_gnt         <= pick_w;
            r_gnt         <= pick_r;
            cmd_instr     <= win_instr;
            cmd_bl        <= win_bl;
            cmd_byte_addr <= win_addr;
            last_gnt_w    <= pick_w;
            if (win_misaligned) begin
               align_err <= 1'b1;
            end else if (pick_w) begin
               w_issued <= w_issued + CNT_W'(1);
            end else begin
               r_issued <= r_issued + CNT_W'(1);
            end
            if (pick_w) begin
               starve_cnt <= 4'd0;
            end else if (w_elig && (starve_cnt != 4'd15)) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mcb_cmd_arbiter.sv
// tb_mcb_cmd_arbiter: directed and randomized checks of mcb_cmd_arbiter against a behavioural model.
module tb_mcb_cmd_arbiter;

   localparam int STARVE_LIMIT = 8;
   localparam int CNT_W        = 8;

   logic             clk;
   logic             reset;
   logic             mem_calib_done;
   logic             cmd_full;
   logic [6:0]       wr_count;
   logic             w_req;
   logic [2:0]       w_instr;
   logic [5:0]       w_bl;
   logic [29:0]      w_addr;
   logic             r_req;
   logic [2:0]       r_instr;
   logic [5:0]       r_bl;
   logic [29:0]      r_addr;
   logic             r_urgent;
   logic             w_gnt;
   logic             r_gnt;
   logic             cmd_en;
   logic [2:0]       cmd_instr;
   logic [5:0]       cmd_bl;
   logic [29:0]      cmd_byte_addr;
   logic             align_err;
   logic [CNT_W-1:0] w_issued;
   logic [CNT_W-1:0] r_issued;

   int tests = 0;
   int fails = 0;
   int calib_off = 0;

   // Behavioural model: after calibration an arbitration decision may happen on
   // any clock edge unless a cooldown from the previous command is running.
   bit m_calib_seen;
   int m_cool;
   int m_starve;
   bit m_last_w;
   bit m_cmd_en;
   bit m_w_gnt;
   bit m_r_gnt;
   bit m_align;
   int m_instr;
   int m_bl;
   int m_addr;
   int m_w_cnt;
   int m_r_cnt;

   mcb_cmd_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_calib_done(mem_calib_done),
      .cmd_full      (cmd_full),
      .wr_count      (wr_count),
      .w_req         (w_req),
      .w_instr       (w_instr),
      .w_bl          (w_bl),
      .w_addr        (w_addr),
      .r_req         (r_req),
      .r_instr       (r_instr),
      .r_bl          (r_bl),
      .r_addr        (r_addr),
      .r_urgent      (r_urgent),
      .w_gnt         (w_gnt),
      .r_gnt         (r_gnt),
      .cmd_en        (cmd_en),
      .cmd_instr     (cmd_instr),
      .cmd_bl        (cmd_bl),
      .cmd_byte_addr (cmd_byte_addr),
      .align_err     (align_err),
      .w_issued      (w_issued),
      .r_issued      (r_issued)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied
   task automatic modelEdge();
      bit we;
      bit re;
      bit win_w;
      bit win_r;
      m_cmd_en = 1'b0;
      m_w_gnt  = 1'b0;
      m_r_gnt  = 1'b0;
      if (reset) begin
         m_calib_seen = 1'b0;
         m_cool       = 0;
         m_starve     = 0;
         m_last_w     = 1'b0;
         m_align      = 1'b0;
         m_instr      = 0;
         m_bl         = 0;
         m_addr       = 0;
         m_w_cnt      = 0;
         m_r_cnt      = 0;
      end else if (!mem_calib_done) begin
         m_calib_seen = 1'b0;
         m_cool       = 0;
      end else if (!m_calib_seen) begin
         m_calib_seen = 1'b1;
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         we    = w_req && !cmd_full && (int'(wr_count) >= int'(w_bl) + 1);
         re    = r_req && !cmd_full;
         win_w = 1'b0;
         win_r = 1'b0;
         if (we && m_starve >= STARVE_LIMIT) win_w = 1'b1;
         else if (re && r_urgent)            win_r = 1'b1;
         else if (we && re) begin
            win_w = !m_last_w;
            win_r = m_last_w;
         end else begin
            win_w = we;
            win_r = re;
         end
         if (win_w || win_r) begin
            if (win_w) m_starve = 0;
            else if (we) m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
            m_last_w = win_w;
            m_w_gnt  = win_w;
            m_r_gnt  = win_r;
            m_instr  = win_w ? int'(w_instr) : int'(r_instr);
            m_bl     = win_w ? int'(w_bl)    : int'(r_bl);
            m_addr   = win_w ? int'(w_addr)  : int'(r_addr);
            if (m_addr % 4 != 0) begin
               m_align = 1'b1;
            end else begin
               m_cmd_en = 1'b1;
               if (win_w) m_w_cnt = (m_w_cnt + 1) % (1 << CNT_W);
               else       m_r_cnt = (m_r_cnt + 1) % (1 << CNT_W);
            end
            m_cool = 2;
         end
      end
   endtask

   task automatic checkModel(input string sect);
      checkOutput({sect, ".cmd_en"}, 32'(cmd_en), 32'(m_cmd_en));
      checkOutput({sect, ".w_gnt"}, 32'(w_gnt), 32'(m_w_gnt));
      checkOutput({sect, ".r_gnt"}, 32'(r_gnt), 32'(m_r_gnt));
      checkOutput({sect, ".instr"}, 32'(cmd_instr), m_instr);
      checkOutput({sect, ".bl"}, 32'(cmd_bl), m_bl);
      checkOutput({sect, ".addr"}, 32'(cmd_byte_addr), m_addr);
      checkOutput({sect, ".align_err"}, 32'(align_err), 32'(m_align));
      checkOutput({sect, ".w_issued"}, 32'(w_issued), m_w_cnt);
      checkOutput({sect, ".r_issued"}, 32'(r_issued), m_r_cnt);
   endtask

   // One clock cycle: predict, clock, then compare on the falling edge
   task automatic applyStimulus(input string sect);
      modelEdge();
      @(posedge clk);
      @(negedge clk);
      checkModel(sect);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus("reset");
      reset = 1'b0;
   endtask

   task automatic idleInputs();
      reset          = 1'b0;
      mem_calib_done = 1'b1;
      cmd_full       = 1'b0;
      wr_count       = 7'd0;
      w_req          = 1'b0;
      w_instr        = 3'd0;
      w_bl           = 6'd0;
      w_addr         = 30'd0;
      r_req          = 1'b0;
      r_instr        = 3'd0;
      r_bl           = 6'd0;
      r_addr         = 30'd0;
      r_urgent       = 1'b0;
   endtask

   function automatic logic [29:0] randAddr();
      logic [29:0] a;
      a = 30'($urandom) & 30'h3FFF_FFFC;
      if ($urandom_range(15) == 0) a[1:0] = 2'($urandom_range(3, 1));
      return a;
   endfunction

   task automatic newWrite();
      w_req   = 1'b1;
      w_instr = 3'($urandom);
      w_bl    = 6'($urandom_range(31, 0));
      w_addr  = randAddr();
   endtask

   task automatic newRead();
      r_req   = 1'b1;
      r_instr = 3'($urandom);
      r_bl    = 6'($urandom_range(63, 0));
      r_addr  = randAddr();
   endtask

   // Directed sequence followed by randomized traffic
   initial begin
      // Reset values
      idleInputs();
      mem_calib_done = 1'b0;
      w_req          = 1'b1;
      w_bl           = 6'd3;
      wr_count       = 7'd64;
      w_addr         = 30'h0000_0100;
      doReset();
      checkOutput("rst_cmd_en", 32'(cmd_en), 0);
      checkOutput("rst_gnt", 32'({w_gnt, r_gnt}), 0);
      checkOutput("rst_align", 32'(align_err), 0);
      checkOutput("rst_addr", 32'(cmd_byte_addr), 0);
      checkOutput("rst_w_issued", 32'(w_issued), 0);
      checkOutput("rst_r_issued", 32'(r_issued), 0);

      // Calibration gate
      for (int i = 0; i < 20; i++) begin
         applyStimulus("calib_hold");
         checkOutput("calib_no_en", 32'(cmd_en), 0);
      end
      mem_calib_done = 1'b1;
      applyStimulus("calib_rise");
      checkOutput("calib_lat1", 32'(cmd_en), 0);
      applyStimulus("calib_rise");
      checkOutput("calib_lat2", 32'(cmd_en), 1);
      checkOutput("calib_wgnt", 32'(w_gnt), 1);

      // Round robin, writer first
      idleInputs();
      w_req    = 1'b1;
      w_instr  = 3'd0;
      wr_count = 7'd64;
      w_addr   = 30'h0000_0040;
      r_req    = 1'b1;
      r_instr  = 3'd1;
      r_bl     = 6'd7;
      r_addr   = 30'h0000_0080;
      doReset();
      applyStimulus("rr");
      for (int j = 0; j < 8; j++) begin
         applyStimulus("rr");
         checkOutput("rr_en", 32'(cmd_en), 1);
         checkOutput("rr_w", 32'(w_gnt), 32'(j % 2 == 0));
         checkOutput("rr_r", 32'(r_gnt), 32'(j % 2 == 1));
         checkOutput("rr_instr", 32'(cmd_instr), j % 2);
         applyStimulus("rr");
         checkOutput("rr_gap1", 32'(cmd_en), 0);
         applyStimulus("rr");
         checkOutput("rr_gap2", 32'(cmd_en), 0);
      end

      // Write-data gating
      idleInputs();
      w_req    = 1'b1;
      w_bl     = 6'd15;
      wr_count = 7'd15;
      w_addr   = 30'h0000_1000;
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus("wgate");
         checkOutput("wgate_none", 32'(w_gnt), 0);
      end
      wr_count = 7'd16;
      applyStimulus("wgate");
      checkOutput("wgate_gnt", 32'(w_gnt), 1);
      checkOutput("wgate_bl", 32'(cmd_bl), 15);

      // Urgency with starvation relief
      idleInputs();
      w_req    = 1'b1;
      wr_count = 7'd64;
      w_addr   = 30'h0000_2000;
      r_req    = 1'b1;
      r_addr   = 30'h0000_3000;
      r_urgent = 1'b1;
      doReset();
      applyStimulus("urg");
      for (int g = 0; g < 18; g++) begin
         applyStimulus("urg");
         checkOutput("urg_w", 32'(w_gnt), 32'(g % 9 == 8));
         checkOutput("urg_r", 32'(r_gnt), 32'(g % 9 != 8));
         applyStimulus("urg");
         applyStimulus("urg");
      end

      // Command FIFO full blocks both requesters
      idleInputs();
      w_req    = 1'b1;
      wr_count = 7'd64;
      r_req    = 1'b1;
      cmd_full = 1'b1;
      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus("full");
         checkOutput("full_gnt", 32'({w_gnt, r_gnt}), 0);
      end
      cmd_full = 1'b0;
      applyStimulus("full");
      checkOutput("full_release", 32'(w_gnt), 1);

      // Misaligned reader address
      idleInputs();
      r_req  = 1'b1;
      r_addr = 30'h0000_0102;
      doReset();
      applyStimulus("misal");
      applyStimulus("misal");
      checkOutput("misal_gnt", 32'(r_gnt), 1);
      checkOutput("misal_en", 32'(cmd_en), 0);
      checkOutput("misal_err", 32'(align_err), 1);
      checkOutput("misal_cnt", 32'(r_issued), 0);
      r_req = 1'b0;
      applyStimulus("misal");
      applyStimulus("misal");
      checkOutput("misal_sticky", 32'(align_err), 1);

      // Issued counter wraps
      idleInputs();
      r_req  = 1'b1;
      r_addr = 30'h0000_0200;
      doReset();
      applyStimulus("wrap");
      for (int n = 0; n < (1 << CNT_W) - 1; n++) begin
         applyStimulus("wrap");
         applyStimulus("wrap");
         applyStimulus("wrap");
      end
      checkOutput("wrap_full", 32'(r_issued), (1 << CNT_W) - 1);
      applyStimulus("wrap");
      checkOutput("wrap_en", 32'(cmd_en), 1);
      checkOutput("wrap_zero", 32'(r_issued), 0);

      // Reset on a would-be issue edge wins
      idleInputs();
      w_req    = 1'b1;
      wr_count = 7'd64;
      r_req    = 1'b1;
      doReset();
      applyStimulus("rst_issue");
      reset = 1'b1;
      applyStimulus("rst_issue");
      checkOutput("rst_issue_en", 32'(cmd_en), 0);
      checkOutput("rst_issue_gnt", 32'({w_gnt, r_gnt}), 0);
      reset = 1'b0;

      // Randomized traffic
      idleInputs();
      doReset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (calib_off > 0) begin
            calib_off--;
            mem_calib_done = 1'b0;
         end else if ($urandom_range(99) == 0) begin
            calib_off      = int'($urandom_range(4, 1));
            mem_calib_done = 1'b0;
         end else begin
            mem_calib_done = 1'b1;
         end
         reset    = ($urandom_range(499) == 0);
         cmd_full = ($urandom_range(7) == 0);
         r_urgent = ($urandom_range(3) == 0);
         wr_count = 7'($urandom_range(80, 0));
         if (!w_req && $urandom_range(2) == 0) newWrite();
         if (!r_req && $urandom_range(2) == 0) newRead();
         applyStimulus("rand");
         if (m_w_gnt) begin
            if ($urandom_range(1) == 1) newWrite();
            else w_req = 1'b0;
         end
         if (m_r_gnt) begin
            if ($urandom_range(1) == 1) newRead();
            else r_req = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
